// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback steps, with memory wait states, illegal
// opcode handling and a retired-instruction counter.
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_WAIT     = 1,
   parameter int unsigned EN_LOGIC_IMM = 1,
   parameter int unsigned TRAP_HALT    = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             memreq,
   output logic             iord,
   output logic             irwrite,
   output logic             pcwrite,
   output logic             branch,
   output logic             memwrite,
   output logic             regwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       immsrc,
   output logic [1:0]       pcsrc,
   output logic [2:0]       aluop,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   localparam int unsigned ST_W = 4;

   localparam logic [ST_W-1:0] S_IDLE    = 4'd0;
   localparam logic [ST_W-1:0] S_FETCH   = 4'd1;
   localparam logic [ST_W-1:0] S_DECODE  = 4'd2;
   localparam logic [ST_W-1:0] S_MEMADR  = 4'd3;
   localparam logic [ST_W-1:0] S_MEMRD   = 4'd4;
   localparam logic [ST_W-1:0] S_MEMWB   = 4'd5;
   localparam logic [ST_W-1:0] S_MEMWR   = 4'd6;
   localparam logic [ST_W-1:0] S_RTYPEEX = 4'd7;
   localparam logic [ST_W-1:0] S_RTYPEWB = 4'd8;
   localparam logic [ST_W-1:0] S_BEQEX   = 4'd9;
   localparam logic [ST_W-1:0] S_IMMEX   = 4'd10;
   localparam logic [ST_W-1:0] S_IMMWB   = 4'd11;
   localparam logic [ST_W-1:0] S_JEX     = 4'd12;
   localparam logic [ST_W-1:0] S_TRAP    = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic [ST_W-1:0]  state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             rdy_c;
   logic             ill_op_c;
   logic             retire_c;

   // Memory handshake; without wait states every access completes at once
   assign rdy_c = (MEM_WAIT != 0) ? mem_ready : 1'b1;

   // State, sticky illegal flag and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   // Next-state, illegal-opcode detection and retirement counting
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      instret_d = instret_q;
      ill_op_c  = 1'b0;
      retire_c  = 1'b0;
      case (state_q)
         S_IDLE:    state_d = S_FETCH;
         S_FETCH:   if (rdy_c) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW:               state_d = S_MEMADR;
               OP_RTYPE:                   state_d = S_RTYPEEX;
               OP_BEQ:                     state_d = S_BEQEX;
               OP_ADDI, OP_ADDIU, OP_LUI:  state_d = S_IMMEX;
               OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                  if (EN_LOGIC_IMM != 0) state_d = S_IMMEX;
                  else                   ill_op_c = 1'b1;
               end
               OP_J:                       state_d = S_JEX;
               default:                    ill_op_c = 1'b1;
            endcase
            if (ill_op_c) begin
               illegal_d = 1'b1;
               state_d   = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
            end
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (rdy_c) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (rdy_c) state_d = S_FETCH;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_IMMEX:   state_d = S_IMMWB;
         S_IMMWB:   state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_IDLE;
      endcase
      // An instruction retires when its final step hands back to FETCH
      case (state_q)
         S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX:
            retire_c = (state_d == S_FETCH);
         default: retire_c = 1'b0;
      endcase
      if (retire_c) instret_d = instret_q + CNT_W'(1);
   end

   // Datapath controls decoded from the current state
   always_comb begin
      memreq   = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      immsrc   = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 3'b000;
      case (state_q)
         S_FETCH: begin
            memreq  = 1'b1;
            alusrcb = 2'b01;
            irwrite = rdy_c;
            pcwrite = rdy_c;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memreq = 1'b1;
            iord   = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memreq   = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 3'b010;
         end
         S_RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = 3'b001;
            branch  = 1'b1;
            pcsrc   = 2'b01;
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               OP_LUI:  immsrc = 2'b10;
               OP_ANDI: begin immsrc = 2'b01; aluop = 3'b100; end
               OP_ORI:  begin immsrc = 2'b01; aluop = 3'b011; end
               OP_XORI: begin immsrc = 2'b01; aluop = 3'b101; end
               OP_SLTI: aluop = 3'b110;
               default: ;
            endcase
         end
         S_IMMWB:   regwrite = 1'b1;
         S_JEX: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign instret = instret_q;
   assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: three parameter variants, per-cycle
// expected control words queued on drive and compared at the falling edge.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [5:0]  op;
      logic        rdy;
      logic [22:0] ctrl;
      logic        ill;
      logic [31:0] cnt;
   } stim_t;

   typedef struct packed {
      logic [22:0] ctrl;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BAD = 6'b111111;

   // {state, memreq,iord,irwrite,pcwrite,branch,memwrite,regwrite,regdst,memtoreg,alusrca, alusrcb, immsrc, pcsrc, aluop}
   function automatic logic [22:0] cv(input logic [3:0] st, input logic [9:0] sb,
                                      input logic [1:0] asb, input logic [1:0] imm,
                                      input logic [1:0] pcs, input logic [2:0] aop);
      return {st, sb, asb, imm, pcs, aop};
   endfunction

   localparam logic [22:0] C_IDLE    = cv(4'd0,  10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_FETCH   = cv(4'd1,  10'b1011000000, 2'b01, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_FETCH_W = cv(4'd1,  10'b1000000000, 2'b01, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_DECODE  = cv(4'd2,  10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_MEMADR  = cv(4'd3,  10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_MEMRD   = cv(4'd4,  10'b1100000000, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_MEMWB   = cv(4'd5,  10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_MEMWR   = cv(4'd6,  10'b1100010000, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_RTEX    = cv(4'd7,  10'b0000000001, 2'b00, 2'b00, 2'b00, 3'b010);
   localparam logic [22:0] C_RTWB    = cv(4'd8,  10'b0000001100, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_BEQEX   = cv(4'd9,  10'b0000100001, 2'b00, 2'b00, 2'b01, 3'b001);
   localparam logic [22:0] C_IMM_ORI = cv(4'd10, 10'b0000000001, 2'b10, 2'b01, 2'b00, 3'b011);
   localparam logic [22:0] C_IMM_LUI = cv(4'd10, 10'b0000000001, 2'b10, 2'b10, 2'b00, 3'b000);
   localparam logic [22:0] C_IMMWB   = cv(4'd11, 10'b0000001000, 2'b00, 2'b00, 2'b00, 3'b000);
   localparam logic [22:0] C_JEX     = cv(4'd12, 10'b0001000000, 2'b00, 2'b00, 2'b10, 3'b000);
   localparam logic [22:0] C_TRAP    = cv(4'd13, 10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b000);

   logic       clk;
   logic [2:0] rst_n;
   logic [5:0] op_i   [3];
   logic       rdy_i  [3];

   logic        memreq_w [3], iord_w [3], irwrite_w [3], pcwrite_w [3], branch_w [3];
   logic        memwrite_w [3], regwrite_w [3], regdst_w [3], memtoreg_w [3], alusrca_w [3];
   logic [1:0]  alusrcb_w [3], immsrc_w [3], pcsrc_w [3];
   logic [2:0]  aluop_w [3];
   logic        illegal_w [3];
   logic [31:0] instret_w [3];
   logic [3:0]  state_w [3];

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: defaults. Instance 1: no wait states, NOP on illegal, 4-bit counter.
   // Instance 2: logical immediates disabled, trap on illegal.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned CW = (g == 1) ? 4 : 32;
      logic [CW-1:0] cnt;
      mips_multicycle_ctrl #(
         .MEM_WAIT    ((g == 1) ? 0 : 1),
         .EN_LOGIC_IMM((g == 2) ? 0 : 1),
         .TRAP_HALT   ((g == 1) ? 0 : 1),
         .CNT_W       (CW)
      ) u_dut (
         .clk      (clk),
         .reset    (rst_n[g]),
         .op       (op_i[g]),
         .mem_ready(rdy_i[g]),
         .memreq   (memreq_w[g]),
         .iord     (iord_w[g]),
         .irwrite  (irwrite_w[g]),
         .pcwrite  (pcwrite_w[g]),
         .branch   (branch_w[g]),
         .memwrite (memwrite_w[g]),
         .regwrite (regwrite_w[g]),
         .regdst   (regdst_w[g]),
         .memtoreg (memtoreg_w[g]),
         .alusrca  (alusrca_w[g]),
         .alusrcb  (alusrcb_w[g]),
         .immsrc   (immsrc_w[g]),
         .pcsrc    (pcsrc_w[g]),
         .aluop    (aluop_w[g]),
         .illegal  (illegal_w[g]),
         .instret  (cnt),
         .state    (state_w[g])
      );
      assign instret_w[g] = 32'(cnt);
   end

   function automatic stim_t mk(input logic [5:0] op, input logic rdy, input logic [22:0] ctrl,
                                input logic ill, input int cnt);
      stim_t s;
      s.op = op; s.rdy = rdy; s.ctrl = ctrl; s.ill = ill; s.cnt = 32'(cnt);
      return s;
   endfunction

   function automatic exp_t observe(input int g);
      exp_t o;
      o.ctrl = {state_w[g], memreq_w[g], iord_w[g], irwrite_w[g], pcwrite_w[g], branch_w[g],
                memwrite_w[g], regwrite_w[g], regdst_w[g], memtoreg_w[g], alusrca_w[g],
                alusrcb_w[g], immsrc_w[g], pcsrc_w[g], aluop_w[g]};
      o.ill  = illegal_w[g];
      o.cnt  = instret_w[g];
      return o;
   endfunction

   // Drive one cycle of stimulus and queue what the DUT must show for it
   task automatic apply(input int g, input stim_t s);
      exp_t e;
      op_i[g]  = s.op;
      rdy_i[g] = s.rdy;
      e.ctrl = s.ctrl; e.ill = s.ill; e.cnt = s.cnt;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_LW, 1'b1, C_IDLE, 1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_IDLE, 1'b0, 0));
      foreach (s[i]) begin
         if (i == 1) rst_n[0] = 1'b1;
         apply(0, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_LW, 1'b1, C_FETCH,  1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_DECODE, 1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_MEMADR, 1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_MEMRD,  1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_MEMWB,  1'b0, 0));
      s.push_back(mk(OP_SW, 1'b0, C_FETCH_W, 1'b0, 1));
      foreach (s[i]) begin
         apply(0, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL lw[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   // Continues in FETCH after one wait cycle, then sw with three write wait states
   task automatic test_fetch_wait_sw();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_SW, 1'b0, C_FETCH_W, 1'b0, 1));
      s.push_back(mk(OP_SW, 1'b1, C_FETCH,   1'b0, 1));
      s.push_back(mk(OP_SW, 1'b0, C_DECODE,  1'b0, 1));
      s.push_back(mk(OP_SW, 1'b0, C_MEMADR,  1'b0, 1));
      s.push_back(mk(OP_SW, 1'b0, C_MEMWR,   1'b0, 1));
      s.push_back(mk(OP_SW, 1'b0, C_MEMWR,   1'b0, 1));
      s.push_back(mk(OP_SW, 1'b0, C_MEMWR,   1'b0, 1));
      s.push_back(mk(OP_SW, 1'b1, C_MEMWR,   1'b0, 1));
      foreach (s[i]) begin
         apply(0, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fetch_sw[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_imm_rtype_beq_j();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_ORI, 1'b1, C_FETCH,   1'b0, 2));
      s.push_back(mk(OP_ORI, 1'b0, C_DECODE,  1'b0, 2));
      s.push_back(mk(OP_ORI, 1'b0, C_IMM_ORI, 1'b0, 2));
      s.push_back(mk(OP_ORI, 1'b0, C_IMMWB,   1'b0, 2));
      s.push_back(mk(OP_LUI, 1'b1, C_FETCH,   1'b0, 3));
      s.push_back(mk(OP_LUI, 1'b1, C_DECODE,  1'b0, 3));
      s.push_back(mk(OP_LUI, 1'b1, C_IMM_LUI, 1'b0, 3));
      s.push_back(mk(OP_LUI, 1'b1, C_IMMWB,   1'b0, 3));
      s.push_back(mk(OP_R,   1'b1, C_FETCH,   1'b0, 4));
      s.push_back(mk(OP_R,   1'b1, C_DECODE,  1'b0, 4));
      s.push_back(mk(OP_R,   1'b1, C_RTEX,    1'b0, 4));
      s.push_back(mk(OP_R,   1'b1, C_RTWB,    1'b0, 4));
      s.push_back(mk(OP_BEQ, 1'b1, C_FETCH,   1'b0, 5));
      s.push_back(mk(OP_BEQ, 1'b1, C_DECODE,  1'b0, 5));
      s.push_back(mk(OP_BEQ, 1'b1, C_BEQEX,   1'b0, 5));
      s.push_back(mk(OP_J,   1'b1, C_FETCH,   1'b0, 6));
      s.push_back(mk(OP_J,   1'b1, C_DECODE,  1'b0, 6));
      s.push_back(mk(OP_J,   1'b1, C_JEX,     1'b0, 6));
      foreach (s[i]) begin
         apply(0, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL exec[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   // Reset asserted while a load waits in MEMRD
   task automatic test_reset_mid();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_LW, 1'b1, C_FETCH,  1'b0, 7));
      s.push_back(mk(OP_LW, 1'b1, C_DECODE, 1'b0, 7));
      s.push_back(mk(OP_LW, 1'b1, C_MEMADR, 1'b0, 7));
      s.push_back(mk(OP_LW, 1'b0, C_MEMRD,  1'b0, 7));
      s.push_back(mk(OP_LW, 1'b0, C_IDLE,   1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_IDLE,   1'b0, 0));
      s.push_back(mk(OP_LW, 1'b1, C_FETCH,  1'b0, 0));
      foreach (s[i]) begin
         if (i == 4) begin
            rst_n[0] = 1'b0;
            #1;
            o = observe(0);
            checks++;
            if (o !== {C_IDLE, 1'b0, 32'd0}) begin
               errors++;
               $display("FAIL reset_async: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=0 cnt=0",
                        o.ctrl, o.ill, o.cnt, C_IDLE);
            end
         end
         if (i == 5) rst_n[0] = 1'b1;
         apply(0, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(0);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   // Logical immediates disabled: ori traps and stays trapped regardless of mem_ready
   task automatic test_logic_imm_off();
      stim_t s[$];
      exp_t  e, o;
      s.push_back(mk(OP_ORI, 1'b1, C_IDLE,   1'b0, 0));
      s.push_back(mk(OP_ORI, 1'b1, C_FETCH,  1'b0, 0));
      s.push_back(mk(OP_ORI, 1'b1, C_DECODE, 1'b0, 0));
      for (int k = 0; k < 12; k++)
         s.push_back(mk((k % 2 == 0) ? OP_ORI : OP_LW, 1'(k % 2), C_TRAP, 1'b1, 0));
      rst_n[2] = 1'b1;
      foreach (s[i]) begin
         apply(2, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(2);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL trap[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   // No wait states, illegal NOP return, single-cycle sw, then counter wrap at 4 bits
   task automatic test_nop_nowait_wrap();
      stim_t s[$];
      exp_t  e, o;
      int    c;
      s.push_back(mk(OP_BAD, 1'b0, C_IDLE,   1'b0, 0));
      s.push_back(mk(OP_BAD, 1'b0, C_FETCH,  1'b0, 0));
      s.push_back(mk(OP_BAD, 1'b0, C_DECODE, 1'b0, 0));
      s.push_back(mk(OP_R,   1'b0, C_FETCH,  1'b1, 0));
      s.push_back(mk(OP_R,   1'b0, C_DECODE, 1'b1, 0));
      s.push_back(mk(OP_R,   1'b0, C_RTEX,   1'b1, 0));
      s.push_back(mk(OP_R,   1'b0, C_RTWB,   1'b1, 0));
      s.push_back(mk(OP_SW,  1'b0, C_FETCH,  1'b1, 1));
      s.push_back(mk(OP_SW,  1'b0, C_DECODE, 1'b1, 1));
      s.push_back(mk(OP_SW,  1'b0, C_MEMADR, 1'b1, 1));
      s.push_back(mk(OP_SW,  1'b0, C_MEMWR,  1'b1, 1));
      c = 2;
      for (int k = 0; k < 15; k++) begin
         s.push_back(mk(OP_J, 1'b0, C_FETCH,  1'b1, c));
         s.push_back(mk(OP_J, 1'b0, C_DECODE, 1'b1, c));
         s.push_back(mk(OP_J, 1'b0, C_JEX,    1'b1, c));
         c = (c + 1) % 16;
      end
      s.push_back(mk(OP_J, 1'b0, C_FETCH, 1'b1, c));
      rst_n[1] = 1'b1;
      foreach (s[i]) begin
         apply(1, s[i]);
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(1);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL nowait[%0d]: got ctrl=%h ill=%b cnt=%0d want ctrl=%h ill=%b cnt=%0d",
                     i, o.ctrl, o.ill, o.cnt, e.ctrl, e.ill, e.cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 3'b000;
      for (int g = 0; g < 3; g++) begin
         op_i[g]  = OP_LW;
         rdy_i[g] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_lw();
      test_fetch_wait_sw();
      test_imm_rtype_beq_j();
      test_reset_mid();
      test_logic_imm_off();
      test_nop_nowait_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multicycle successor to the single-cycle main decoder.
- A Moore-style FSM sequences the fetch, decode, execute, memory and writeback steps of each MIPS instruction, and drives the datapath enables and muxes of a shared-memory multicycle datapath.
- Adds memory wait-state handshaking, optional logical-immediate instructions, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- MEM_WAIT, 1: 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored (treated as 1).
- EN_LOGIC_IMM, 1: 1 = andi/ori/xori/slti decoded; 0 = those opcodes are illegal.
- TRAP_HALT, 1: 1 = illegal opcode parks in TRAP until reset; 0 = illegal opcode flags and returns to FETCH (NOP).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instruction opcode from instruction register.
- mem_ready  in  1  memory completes access this cycle.
- memreq  out  1  memory access request.
- iord  out  1  0 = address from PC, 1 = from ALUOut.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  PC write if zero flag.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = write data from memory data register.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate << 2.
- immsrc  out  2  00 = sign-extend, 01 = zero-extend, 10 = imm << 16.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  3  000 = add, 001 = sub, 010 = funct, 011 = or, 100 = and, 101 = xor, 110 = slt.
- illegal  out  1  sticky illegal-opcode flag.
- instret  out  CNT_W  count of retired instructions.
- state  out  4  current state (debug).

Behaviour:
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, RTYPEEX = 7, RTYPEWB = 8, BEQEX = 9, IMMEX = 10, IMMWB = 11, JEX = 12, TRAP = 13.
- Reset asserted (reset = 0), at any time including mid-instruction: state = IDLE, illegal = 0, instret = 0. All outputs are 0 in IDLE.
- IDLE -> FETCH on the first clock after reset releases.
- FETCH: memreq = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 000, pcsrc = 00.
  - irwrite and pcwrite equal rdy (rdy = mem_ready when MEM_WAIT = 1, else 1).
  - Stays in FETCH while rdy = 0; moves to DECODE when rdy = 1.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 000 (branch target computed). Next state by op:
  - 100011 (lw) / 101011 (sw) -> MEMADR.
  - 000000 -> RTYPEEX.
  - 000100 -> BEQEX.
  - 001000 / 001001 / 001111 -> IMMEX.
  - 001100 / 001101 / 001110 / 001010 -> IMMEX when EN_LOGIC_IMM = 1, else illegal.
  - 000010 -> JEX.
  - Any other op: illegal set to 1; next state TRAP when TRAP_HALT = 1, else FETCH.
- MEMADR: alusrca = 1, alusrcb = 10, immsrc = 00, aluop = 000. Next MEMRD for lw, MEMWR for sw.
- MEMRD: memreq = 1, iord = 1. Holds until rdy, then MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0 -> FETCH.
- MEMWR: memreq = 1, iord = 1, memwrite = 1 for every cycle in the state. Holds until rdy, then FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 010 -> RTYPEWB.
- RTYPEWB: regwrite = 1, regdst = 1, memtoreg = 0 -> FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 001, branch = 1, pcsrc = 01 -> FETCH.
- IMMEX: alusrca = 1, alusrcb = 10 -> IMMWB. immsrc/aluop by op:
  - addi/addiu: 00 / 000.
  - lui: 10 / 000.
  - andi: 01 / 100.
  - ori: 01 / 011.
  - xori: 01 / 101.
  - slti: 00 / 110.
- IMMWB: regwrite = 1, regdst = 0, memtoreg = 0 -> FETCH.
- JEX: pcwrite = 1, pcsrc = 10 -> FETCH.
- TRAP: all strobes 0. Exit only via reset.
- op is sampled in DECODE, MEMADR and IMMEX only; the instruction register is stable after FETCH.
- Unlisted outputs are 0 in every state; there are no X outputs.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, IMMWB or JEX. It wraps modulo 2^CNT_W. The illegal-NOP return does not increment it.
- illegal stays 1 until reset.
- mem_ready outside FETCH/MEMRD/MEMWR has no effect.

Test Plan:
- lw, mem_ready = 1 throughout -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH (5 cycles); regwrite = 1 and memtoreg = 1 only in MEMWB; instret 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite = 1 for 4 consecutive cycles, then FETCH; with MEM_WAIT = 0, exactly 1 cycle.
- FETCH with mem_ready = 0 for 2 cycles -> irwrite = pcwrite = 0 in those cycles, 1 in the third, then DECODE.
- ori (001101) -> IMMEX with immsrc = 01, aluop = 011; with EN_LOGIC_IMM = 0 -> illegal = 1 and state = TRAP, held for 10+ cycles.
- op = 111111 with TRAP_HALT = 0 -> illegal = 1, back to FETCH, instret unchanged; a following add completes in 4 cycles.
- reset pulled low in MEMRD -> state = 0 and all outputs 0 immediately; after release IDLE -> FETCH, instret = 0; counter wraps 2^CNT_W - 1 -> 0 with CNT_W = 4.
